// File: rtl/minv_pkg.sv
// Shared state encoding and width defaults for the modular-inverse host interface.
package minv_pkg;

  localparam int unsigned RES_W      = 256;
  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned DEF_BEATS  = RES_W / DEF_WORD_W;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBusy,
    StCollect,
    StResp
  } minv_state_e;

endpackage

// File: rtl/minv_res_asm.sv
// Result assembly: beat counter plus indexed capture of engine beats, LS word first.
module minv_res_asm
  import minv_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned BEATS  = DEF_BEATS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     cap,
  input  logic [WORD_W-1:0]        word,
  output logic [WORD_W*BEATS-1:0]  data,
  output logic                     last
);

  localparam int unsigned CNT_W = $clog2(BEATS) + 1;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]             cnt_q;
  logic [BEATS-1:0][WORD_W-1:0] words_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      words_q <= '0;
    end else if (clr) begin
      cnt_q   <= '0;
      words_q <= '0;
    end else if (cap && (cnt_q < CNT_FULL)) begin
      words_q[cnt_q[IDX_W-1:0]] <= word;
      cnt_q                     <= cnt_q + CNT_W'(1);
    end
  end

  assign data = words_q;
  // High while the next capture would complete the burst.
  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/minv_host_if.sv
// Host-side job sequencer for the inversion engine: start pulse, timeout, burst collection.
module minv_host_if
  import minv_pkg::*;
#(
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned BEATS       = DEF_BEATS,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic                     minv_en,
  input  logic                     has_done,
  output logic                     out_ready,
  input  logic                     out_valid,
  input  logic [WORD_W-1:0]        res_word,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_W*BEATS-1:0]  rsp_data,
  output logic                     rsp_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  minv_state_e      state_q;
  logic [TMO_W-1:0] tmo_q;
  logic             asm_clr;
  logic             asm_cap;
  logic             asm_last;

  // Beats are only taken while the engine window is open.
  assign asm_cap = ((state_q == StBusy) || (state_q == StCollect)) && out_valid;
  assign asm_clr = (state_q == StStart);

  minv_res_asm #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS)
  ) u_res_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (asm_clr),
    .cap  (asm_cap),
    .word (res_word),
    .data (rsp_data),
    .last (asm_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      cmd_ready <= 1'b0;
      minv_en   <= 1'b0;
      out_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= 1'b0;
      minv_en   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && has_done) begin
            cmd_ready <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          minv_en   <= 1'b1;
          tmo_q     <= '0;
          rsp_err   <= 1'b0;
          out_ready <= 1'b1;
          state_q   <= StBusy;
        end
        StBusy: begin
          if (out_valid) begin
            if (asm_last) begin
              out_ready <= 1'b0;
              rsp_valid <= 1'b1;
              state_q   <= StResp;
            end else begin
              state_q <= StCollect;
            end
          end else if (tmo_q == TMO_LAST) begin
            rsp_err   <= 1'b1;
            out_ready <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        StCollect: begin
          // A gap in out_valid ends the burst early; partial data is kept.
          if (!out_valid) begin
            rsp_err   <= 1'b1;
            out_ready <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else if (asm_last) begin
            out_ready <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
